// File: rtl/fb_pkg.sv
// Shared types and defaults for the UART framebuffer write path.
// Parser states, packet header and address width.
package fb_pkg;

  localparam int         FB_ADDR_W    = 16;
  localparam logic [7:0] FB_HEADER    = 8'h55;
  localparam int         FB_TIMEOUT   = 52080;
  localparam int         FB_STALL_MAX = 64;

  typedef enum logic [1:0] {
    IDLE,
    AH,
    AL,
    DAT
  } pstate_e;

endpackage

// File: rtl/uart_fb_wr_arbiter_if.sv
// Bus bundle for the UART write arbiter: byte input,
// video read request and framebuffer RAM port.
interface uart_fb_wr_arbiter_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              vid_rd_req;
  logic [ADDR_W-1:0] vid_rd_addr;
  logic              vid_rd_ack;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              pkt_err;
  logic              ovr_err;
  logic              wr_busy;

  modport master (
    output rx_data, rx_valid,
    output vid_rd_req, vid_rd_addr,
    input  vid_rd_ack, ram_en, ram_we,
    input  ram_addr, ram_wdata,
    input  pkt_err, ovr_err, wr_busy
  );

  modport slave (
    input  rx_data, rx_valid,
    input  vid_rd_req, vid_rd_addr,
    output vid_rd_ack, ram_en, ram_we,
    output ram_addr, ram_wdata,
    output pkt_err, ovr_err, wr_busy
  );

endinterface

// File: rtl/fb_pkt_parser.sv
// Packet parser: HEADER, ADDR_HI, ADDR_LO, DATA with
// an inter-byte timeout while a packet is open.
module fb_pkt_parser
  import fb_pkg::*;
#(
  parameter int         ADDR_W  = FB_ADDR_W,
  parameter logic [7:0] HEADER  = FB_HEADER,
  parameter int         TIMEOUT = FB_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              pkt_done_o,
  output logic [ADDR_W-1:0] pkt_addr_o,
  output logic [7:0]        pkt_data_o,
  output logic              pkt_err_o
);

  localparam int GW = $clog2(TIMEOUT + 1);

  pstate_e       state_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    hi_q;
  logic [7:0]    lo_q;
  logic          err_q;
  logic [15:0]   addr_full;

  assign addr_full  = {hi_q, lo_q};
  assign pkt_addr_o = addr_full[ADDR_W-1:0];
  assign pkt_data_o = rx_data_i;
  assign pkt_done_o = rx_valid_i && (state_q == DAT);
  assign pkt_err_o  = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gap_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          gap_q <= '0;
          if (rx_valid_i) begin
            if (rx_data_i == HEADER) state_q <= AH;
            else err_q <= 1'b1;
          end
        end
        default: begin
          if (rx_valid_i) begin
            gap_q <= '0;
            if (state_q == AH) begin
              hi_q    <= rx_data_i;
              state_q <= AL;
            end else if (state_q == AL) begin
              lo_q    <= rx_data_i;
              state_q <= DAT;
            end else begin
              state_q <= IDLE;
            end
          end else if (gap_q == GW'(TIMEOUT - 1)) begin
            // Sender went quiet mid-packet: abandon it.
            gap_q   <= '0;
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_fb_wr_arbiter.sv
// Single-entry write buffer plus RAM port arbiter; video
// reads win unless a pending write has stalled too long.
module uart_fb_wr_arbiter
  import fb_pkg::*;
#(
  parameter int         ADDR_W    = FB_ADDR_W,
  parameter logic [7:0] HEADER    = FB_HEADER,
  parameter int         TIMEOUT   = FB_TIMEOUT,
  parameter int         STALL_MAX = FB_STALL_MAX
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  uart_fb_wr_arbiter_if.slave bus
);

  localparam int SW = $clog2(STALL_MAX + 1);

  logic              pkt_done;
  logic [ADDR_W-1:0] pkt_addr;
  logic [7:0]        pkt_data;
  logic              pkt_err;

  logic              issue;
  logic              load;
  logic              drop;

  logic              wr_busy_q, wr_busy_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]        buf_data_q, buf_data_d;
  logic [SW-1:0]     stall_q, stall_d;
  logic              ovr_q, ovr_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic              ack_q, ack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  fb_pkt_parser #(
    .ADDR_W  (ADDR_W),
    .HEADER  (HEADER),
    .TIMEOUT (TIMEOUT)
  ) u_parser (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .rx_data_i  (bus.rx_data),
    .rx_valid_i (bus.rx_valid),
    .pkt_done_o (pkt_done),
    .pkt_addr_o (pkt_addr),
    .pkt_data_o (pkt_data),
    .pkt_err_o  (pkt_err)
  );

  always_comb begin
    issue = wr_busy_q &&
            (!bus.vid_rd_req || stall_q == SW'(STALL_MAX));
    // A slot freed by this cycle's write can take the new packet.
    load  = pkt_done && (!wr_busy_q || issue);
    drop  = pkt_done && wr_busy_q && !issue;

    wr_busy_d  = wr_busy_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    stall_d    = stall_q;
    ovr_d      = ovr_q | drop;
    en_d       = 1'b0;
    we_d       = 1'b0;
    ack_d      = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    unique case (1'b1)
      issue: begin
        en_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = buf_addr_q;
        wdata_d = buf_data_q;
      end
      (!issue && bus.vid_rd_req): begin
        en_d   = 1'b1;
        ack_d  = 1'b1;
        addr_d = bus.vid_rd_addr;
      end
      default: ;
    endcase

    if (load) begin
      wr_busy_d  = 1'b1;
      buf_addr_d = pkt_addr;
      buf_data_d = pkt_data;
      stall_d    = '0;
    end else if (issue) begin
      wr_busy_d = 1'b0;
      stall_d   = '0;
    end else if (wr_busy_q && stall_q != SW'(STALL_MAX)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_busy_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      stall_q    <= '0;
      ovr_q      <= 1'b0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      ack_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      wr_busy_q  <= wr_busy_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      stall_q    <= stall_d;
      ovr_q      <= ovr_d;
      en_q       <= en_d;
      we_q       <= we_d;
      ack_q      <= ack_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.vid_rd_ack = ack_q;
  assign bus.ram_en     = en_q;
  assign bus.ram_we     = we_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.pkt_err    = pkt_err;
  assign bus.ovr_err    = ovr_q;
  assign bus.wr_busy    = wr_busy_q;

endmodule

// File: tb/tb_uart_fb_wr_arbiter.sv
// Scoreboard bench for uart_fb_wr_arbiter: expected writes and
// errors are queued by stimulus and popped by a monitor.
module tb_uart_fb_wr_arbiter;

  localparam int TO = 52080;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;

  wr_t exp_wr[$];
  int  exp_err[$];

  uart_fb_wr_arbiter_if #(.ADDR_W(16)) bus ();

  uart_fb_wr_arbiter #(
    .ADDR_W    (16),
    .HEADER    (8'h55),
    .TIMEOUT   (TO),
    .STALL_MAX (64)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus.slave)
  );

  always #20 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send(logic [7:0] b, int gap);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(string nm);
    repeat (6) @(negedge clk);
    chk({nm, "_wr_left"}, exp_wr.size(), 0);
    chk({nm, "_err_left"}, exp_err.size(), 0);
  endtask

  function automatic logic [31:0] outs();
    return {2'b0, bus.ram_en, bus.ram_we, bus.ram_addr,
            bus.ram_wdata, bus.vid_rd_ack, bus.pkt_err,
            bus.ovr_err, bus.wr_busy};
  endfunction

  // Monitor: compares every RAM write and pkt_err pulse.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (bus.ram_we) begin
        n_wr++;
        chk("we_has_en", bus.ram_en, 1);
        chk("wr_ack_low", bus.vid_rd_ack, 0);
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got %h<=%h want none",
                   bus.ram_addr, bus.ram_wdata);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", bus.ram_addr, e.a);
          chk("wr_data", bus.ram_wdata, e.d);
        end
      end else if (bus.ram_en) begin
        chk("rd_ack", bus.vid_rd_ack, 1);
      end else if (bus.vid_rd_ack) begin
        chk("ack_no_en", bus.vid_rd_ack, 0);
      end
      if (bus.pkt_err) begin
        if (exp_err.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pkt_err: got 1 want 0");
        end else begin
          void'(exp_err.pop_front());
          n_cmp++;
        end
      end
    end
  end

  initial begin
    int acks;
    int got;
    int w0;
    bus.rx_data     = '0;
    bus.rx_valid    = 1'b0;
    bus.vid_rd_req  = 1'b0;
    bus.vid_rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 0);
    rst = 1'b0;

    // 1: plain write, no video traffic
    w0 = n_wr;
    send(8'h55, 2);
    send(8'h01, 2);
    send(8'h02, 2);
    exp_wr.push_back('{16'h0102, 8'hAB});
    send(8'hAB, 0);
    chk("t1_busy", bus.wr_busy, 1);
    got = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.ram_we) got = 1;
    end
    chk("t1_latency", got, 1);
    chk("t1_busy_clr", bus.wr_busy, 0);
    drain("t1");
    chk("t1_one_write", n_wr - w0, 1);

    // 2: bad header then good packet
    exp_err.push_back(1);
    send(8'h00, 3);
    send(8'h55, 1);
    send(8'h00, 1);
    send(8'h10, 1);
    exp_wr.push_back('{16'h0010, 8'h3C});
    send(8'h3C, 0);
    drain("t2");

    // 3: inter-byte timeout, then stray byte
    w0 = n_wr;
    send(8'h55, 2);
    exp_err.push_back(1);
    send(8'h01, 0);
    repeat (TO + 1) @(negedge clk);
    chk("t3_to_err", exp_err.size(), 0);
    exp_err.push_back(1);
    send(8'h02, 2);
    drain("t3");
    chk("t3_no_write", n_wr - w0, 0);

    // 4: constant video reads, write forced at stall limit
    bus.vid_rd_req  = 1'b1;
    bus.vid_rd_addr = 16'h1000;
    send(8'h55, 1);
    send(8'h03, 1);
    send(8'h05, 1);
    exp_wr.push_back('{16'h0305, 8'h5A});
    send(8'h5A, 0);
    acks = 0;
    got  = 0;
    for (int k = 0; k < 200 && got == 0; k++) begin
      @(negedge clk);
      if (bus.ram_we) got = 1;
      else begin
        if (bus.vid_rd_ack) acks++;
        bus.vid_rd_addr = bus.vid_rd_addr + 16'd1;
      end
    end
    chk("t4_write_seen", got, 1);
    chk("t4_reads_before", acks, 64);
    chk("t4_ack_in_wr", bus.vid_rd_ack, 0);
    @(negedge clk);
    chk("t4_ack_resume", bus.vid_rd_ack, 1);
    chk("t4_rd_addr", bus.ram_addr, bus.vid_rd_addr);
    chk("t4_ovr_clear", bus.ovr_err, 0);
    drain("t4");

    // 5: second packet while first is still stalled
    send(8'h55, 1);
    send(8'h02, 1);
    send(8'h00, 1);
    exp_wr.push_back('{16'h0200, 8'h11});
    send(8'h11, 1);
    send(8'h55, 1);
    send(8'h03, 1);
    send(8'h00, 1);
    send(8'h22, 1);
    chk("t5_ovr_set", bus.ovr_err, 1);
    got = 0;
    for (int k = 0; k < 200 && got == 0; k++) begin
      @(negedge clk);
      if (bus.ram_we) got = 1;
    end
    chk("t5_write_seen", got, 1);
    repeat (10) @(negedge clk);
    chk("t5_ovr_sticky", bus.ovr_err, 1);
    chk("t5_busy_clr", bus.wr_busy, 0);
    drain("t5");
    bus.vid_rd_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_ovr_rst", bus.ovr_err, 0);
    rst = 1'b0;

    // 6: reset mid-packet discards it
    w0 = n_wr;
    send(8'h55, 2);
    send(8'h01, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_outs", outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_err.push_back(1);
    exp_err.push_back(1);
    send(8'h02, 2);
    send(8'hAB, 2);
    drain("t6");
    chk("t6_no_write", n_wr - w0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
